// File: rtl/sata_fis_pkg.sv
// Shared FIS type codes, parser FSM states and captured-field records for the
// SATA RX FIS command-layer front end.
package sata_fis_pkg;

    localparam logic [7:0] FIS_REG_D2H   = 8'h34;
    localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_DATA      = 8'h46;

    // Register D2H and PIO Setup are both five dwords long.
    localparam int REG_FIS_DW = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_PIO,
        ST_DATA,
        ST_SKIP
    } fis_state_e;

    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  error;
        logic        irq;
        logic [7:0]  device;
        logic [47:0] lba;
        logic [15:0] count;
    } reg_fis_t;

    typedef struct packed {
        logic [7:0]  estatus;
        logic [15:0] xfer_cnt;
    } pio_fis_t;

endpackage

// File: rtl/sata_rfis_parser.sv
// RX FIS classifier: captures Register D2H / PIO Setup fields, forwards Data FIS
// payload, and pulses error strobes. Define SATA_RFIS_STATS_EN for FIS/error counters.
module sata_rfis_parser
    import sata_fis_pkg::*;
#(
    parameter int MAX_DATA_DW = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rfis_tvalid,
    input  logic        rfis_tlast,
    input  logic [31:0] rfis_tdata,
    input  logic        rfis_err,
    output logic        reg_valid,
    output logic [7:0]  reg_status,
    output logic [7:0]  reg_error,
    output logic        reg_irq,
    output logic [7:0]  reg_device,
    output logic [47:0] reg_lba,
    output logic [15:0] reg_count,
    output logic        pio_valid,
    output logic [7:0]  pio_estatus,
    output logic [15:0] pio_xfer_cnt,
    output logic        dma_act,
    output logic        data_tvalid,
    output logic        data_tlast,
    output logic [31:0] data_tdata,
    output logic        data_abort,
    output logic        fis_err
`ifdef SATA_RFIS_STATS_EN
    ,
    output logic [31:0] stat_fis_cnt,
    output logic [31:0] stat_err_cnt
`endif
);

    localparam int CW = $clog2(MAX_DATA_DW + 2);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] CNT_REG_LAST = CW'(REG_FIS_DW - 1);
    localparam logic [CW-1:0] DATA_LIM     = CW'(MAX_DATA_DW);

    fis_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    reg_fis_t    sh_reg_q, sh_reg_d;
    logic [7:0]  sh_estatus_q, sh_estatus_d;
    logic        skip_err_q, skip_err_d;
    logic        trunc_q, trunc_d;
    logic        last_data_q, last_data_d;

    reg_fis_t    reg_q, reg_d;
    pio_fis_t    pio_q, pio_d;
    logic        reg_valid_q, reg_valid_d;
    logic        pio_valid_q, pio_valid_d;
    logic        dma_act_q, dma_act_d;
    logic        data_tvalid_q, data_tvalid_d;
    logic        data_tlast_q, data_tlast_d;
    logic [31:0] data_tdata_q, data_tdata_d;
    logic        data_abort_q, data_abort_d;
    logic        fis_err_q, fis_err_d;

    logic [7:0]  fis_type;
    assign fis_type = rfis_tdata[7:0];
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_reg_d      = sh_reg_q;
        sh_estatus_d  = sh_estatus_q;
        skip_err_d    = skip_err_q;
        trunc_d       = 1'b0;
        last_data_d   = last_data_q;
        reg_d         = reg_q;
        pio_d         = pio_q;
        reg_valid_d   = 1'b0;
        pio_valid_d   = 1'b0;
        dma_act_d     = 1'b0;
        data_tvalid_d = 1'b0;
        data_tlast_d  = 1'b0;
        data_tdata_d  = data_tdata_q;
        // A truncation flagged last cycle reports one cycle after the forced tlast.
        data_abort_d  = trunc_q;
        fis_err_d     = trunc_q;

        if (rfis_err) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            fis_err_d    = 1'b1;
            data_abort_d = trunc_q | last_data_q;
            last_data_d  = 1'b0;
            skip_err_d   = 1'b0;
        end else if (rfis_tvalid) begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d           = CW'(1);
                    sh_reg_d.status = rfis_tdata[23:16];
                    sh_reg_d.error  = rfis_tdata[31:24];
                    sh_reg_d.irq    = rfis_tdata[14];
                    last_data_d     = (fis_type == FIS_DATA) && !rfis_tlast;
                    if (rfis_tlast) begin
                        if (fis_type == FIS_DMA_ACT) dma_act_d = 1'b1;
                        else                         fis_err_d = 1'b1;
                    end else begin
                        case (fis_type)
                            FIS_REG_D2H:   state_d = ST_REG;
                            FIS_PIO_SETUP: state_d = ST_PIO;
                            FIS_DATA:      state_d = ST_DATA;
                            default: begin
                                state_d    = ST_SKIP;
                                skip_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                ST_REG, ST_PIO: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CW'(1)) begin
                        sh_reg_d.device    = rfis_tdata[31:24];
                        sh_reg_d.lba[23:0] = rfis_tdata[23:0];
                    end else if (cnt_q == CW'(2)) begin
                        sh_reg_d.lba[47:24] = rfis_tdata[23:0];
                    end else if (cnt_q == CW'(3)) begin
                        sh_reg_d.count = rfis_tdata[15:0];
                        sh_estatus_d   = rfis_tdata[31:24];
                    end
                    if (rfis_tlast) begin
                        state_d = ST_IDLE;
                        if (cnt_q != CNT_REG_LAST) begin
                            fis_err_d = 1'b1;
                        end else if (state_q == ST_REG) begin
                            reg_d       = sh_reg_q;
                            reg_valid_d = 1'b1;
                        end else begin
                            pio_d       = '{estatus: sh_estatus_q, xfer_cnt: rfis_tdata[15:0]};
                            pio_valid_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    cnt_d         = cnt_inc;
                    data_tvalid_d = 1'b1;
                    data_tdata_d  = rfis_tdata;
                    if (rfis_tlast) begin
                        data_tlast_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (cnt_q == DATA_LIM) begin
                        // Oversize payload: close the stream here, drop the rest silently.
                        data_tlast_d = 1'b1;
                        trunc_d      = 1'b1;
                        skip_err_d   = 1'b0;
                        state_d      = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (rfis_tlast) begin
                        if (skip_err_q) fis_err_d = 1'b1;
                        skip_err_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sh_reg_q      <= '0;
            sh_estatus_q  <= '0;
            skip_err_q    <= 1'b0;
            trunc_q       <= 1'b0;
            last_data_q   <= 1'b0;
            reg_q         <= '0;
            pio_q         <= '0;
            reg_valid_q   <= 1'b0;
            pio_valid_q   <= 1'b0;
            dma_act_q     <= 1'b0;
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
            data_tdata_q  <= '0;
            data_abort_q  <= 1'b0;
            fis_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_reg_q      <= sh_reg_d;
            sh_estatus_q  <= sh_estatus_d;
            skip_err_q    <= skip_err_d;
            trunc_q       <= trunc_d;
            last_data_q   <= last_data_d;
            reg_q         <= reg_d;
            pio_q         <= pio_d;
            reg_valid_q   <= reg_valid_d;
            pio_valid_q   <= pio_valid_d;
            dma_act_q     <= dma_act_d;
            data_tvalid_q <= data_tvalid_d;
            data_tlast_q  <= data_tlast_d;
            data_tdata_q  <= data_tdata_d;
            data_abort_q  <= data_abort_d;
            fis_err_q     <= fis_err_d;
        end
    end

    assign reg_valid    = reg_valid_q;
    assign reg_status   = reg_q.status;
    assign reg_error    = reg_q.error;
    assign reg_irq      = reg_q.irq;
    assign reg_device   = reg_q.device;
    assign reg_lba      = reg_q.lba;
    assign reg_count    = reg_q.count;
    assign pio_valid    = pio_valid_q;
    assign pio_estatus  = pio_q.estatus;
    assign pio_xfer_cnt = pio_q.xfer_cnt;
    assign dma_act      = dma_act_q;
    assign data_tvalid  = data_tvalid_q;
    assign data_tlast   = data_tlast_q;
    assign data_tdata   = data_tdata_q;
    assign data_abort   = data_abort_q;
    assign fis_err      = fis_err_q;

`ifdef SATA_RFIS_STATS_EN
    logic [31:0] stat_fis_cnt_q, stat_fis_cnt_d;
    logic [31:0] stat_err_cnt_q, stat_err_cnt_d;

    // An rfis_err in IDLE refers to a FIS already counted at its tlast.
    always_comb begin
        stat_fis_cnt_d = stat_fis_cnt_q;
        stat_err_cnt_d = stat_err_cnt_q;
        if ((rfis_tvalid && rfis_tlast) || (rfis_err && state_q != ST_IDLE))
            stat_fis_cnt_d = stat_fis_cnt_q + 32'd1;
        if (fis_err_d)
            stat_err_cnt_d = stat_err_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fis_cnt_q <= '0;
            stat_err_cnt_q <= '0;
        end else begin
            stat_fis_cnt_q <= stat_fis_cnt_d;
            stat_err_cnt_q <= stat_err_cnt_d;
        end
    end

    assign stat_fis_cnt = stat_fis_cnt_q;
    assign stat_err_cnt = stat_err_cnt_q;
`endif

endmodule

// File: tb/tb_sata_rfis_parser.sv
// Directed bench for sata_rfis_parser: a default-size instance plus a
// MAX_DATA_DW=4 instance on the same input stream for truncation.
module tb_sata_rfis_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        rfis_tvalid, rfis_tlast, rfis_err;
    logic [31:0] rfis_tdata;

    logic        reg_valid, reg_irq, pio_valid, dma_act, data_tvalid, data_tlast, data_abort, fis_err;
    logic [7:0]  reg_status, reg_error, reg_device, pio_estatus;
    logic [47:0] reg_lba;
    logic [15:0] reg_count, pio_xfer_cnt;
    logic [31:0] data_tdata;

    logic        s_reg_valid, s_reg_irq, s_pio_valid, s_dma_act, s_data_tvalid, s_data_tlast, s_data_abort, s_fis_err;
    logic [7:0]  s_reg_status, s_reg_error, s_reg_device, s_pio_estatus;
    logic [47:0] s_reg_lba;
    logic [15:0] s_reg_count, s_pio_xfer_cnt;
    logic [31:0] s_data_tdata;
`ifdef SATA_RFIS_STATS_EN
    logic [31:0] stat_fis_cnt, stat_err_cnt, s_stat_fis_cnt, s_stat_err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sata_rfis_parser dut (
        .clk(clk), .rst(rst), .rfis_tvalid(rfis_tvalid), .rfis_tlast(rfis_tlast),
        .rfis_tdata(rfis_tdata), .rfis_err(rfis_err),
        .reg_valid(reg_valid), .reg_status(reg_status), .reg_error(reg_error), .reg_irq(reg_irq),
        .reg_device(reg_device), .reg_lba(reg_lba), .reg_count(reg_count),
        .pio_valid(pio_valid), .pio_estatus(pio_estatus), .pio_xfer_cnt(pio_xfer_cnt),
        .dma_act(dma_act), .data_tvalid(data_tvalid), .data_tlast(data_tlast),
        .data_tdata(data_tdata), .data_abort(data_abort), .fis_err(fis_err)
`ifdef SATA_RFIS_STATS_EN
        , .stat_fis_cnt(stat_fis_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    sata_rfis_parser #(.MAX_DATA_DW(4)) dut_small (
        .clk(clk), .rst(rst), .rfis_tvalid(rfis_tvalid), .rfis_tlast(rfis_tlast),
        .rfis_tdata(rfis_tdata), .rfis_err(rfis_err),
        .reg_valid(s_reg_valid), .reg_status(s_reg_status), .reg_error(s_reg_error), .reg_irq(s_reg_irq),
        .reg_device(s_reg_device), .reg_lba(s_reg_lba), .reg_count(s_reg_count),
        .pio_valid(s_pio_valid), .pio_estatus(s_pio_estatus), .pio_xfer_cnt(s_pio_xfer_cnt),
        .dma_act(s_dma_act), .data_tvalid(s_data_tvalid), .data_tlast(s_data_tlast),
        .data_tdata(s_data_tdata), .data_abort(s_data_abort), .fis_err(s_fis_err)
`ifdef SATA_RFIS_STATS_EN
        , .stat_fis_cnt(s_stat_fis_cnt), .stat_err_cnt(s_stat_err_cnt)
`endif
    );

    // Advance to just after the next rising edge; registered outputs then reflect the beat just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        rfis_tvalid = 1'b1;
        rfis_tdata  = d;
        rfis_tlast  = l;
        tick();
    endtask

    task automatic idle();
        rfis_tvalid = 1'b0;
        rfis_tlast  = 1'b0;
        rfis_tdata  = 32'h0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rfis_tvalid = 1'b0; rfis_tlast = 1'b0; rfis_tdata = 32'h0; rfis_err = 1'b0;
        tick(); tick();
        n_tests++; if ({reg_valid, pio_valid, dma_act, data_tvalid, data_tlast, data_abort, fis_err} !== 7'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0", {reg_valid, pio_valid, dma_act, data_tvalid, data_tlast, data_abort, fis_err}); end
        n_tests++; if ({reg_status, reg_error, reg_irq, reg_device, reg_lba, reg_count} !== 89'b0) begin n_fail++; $display("FAIL reset_reg: lba %h status %h", reg_lba, reg_status); end
        n_tests++; if ({pio_estatus, pio_xfer_cnt, data_tdata} !== 56'b0) begin n_fail++; $display("FAIL reset_pio_data: got %h want 0", {pio_estatus, pio_xfer_cnt, data_tdata}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reg_d2h();
        // status=0x50 in byte 2, error=0x00 in byte 3, I bit = dw0[14]
        beat(32'h0050_4034, 1'b0);
        beat(32'hE012_3456, 1'b0);
        beat(32'h0000_789A, 1'b0);
        beat(32'h0000_0010, 1'b0);
        n_tests++; if (reg_valid !== 1'b0) begin n_fail++; $display("FAIL reg_early: reg_valid %b want 0", reg_valid); end
        beat(32'h0000_0000, 1'b1);
        n_tests++; if (reg_valid !== 1'b1) begin n_fail++; $display("FAIL reg_valid: got %b want 1", reg_valid); end
        n_tests++; if (reg_status !== 8'h50 || reg_error !== 8'h00 || reg_irq !== 1'b1) begin n_fail++; $display("FAIL reg_status: got %h/%h/%b want 50/00/1", reg_status, reg_error, reg_irq); end
        n_tests++; if (reg_lba !== 48'h00789A123456) begin n_fail++; $display("FAIL reg_lba: got %h want 00789a123456", reg_lba); end
        n_tests++; if (reg_device !== 8'hE0 || reg_count !== 16'h0010) begin n_fail++; $display("FAIL reg_dev_cnt: got %h/%h want e0/0010", reg_device, reg_count); end
        n_tests++; if (fis_err !== 1'b0) begin n_fail++; $display("FAIL reg_no_err: fis_err %b want 0", fis_err); end
        idle();
        n_tests++; if (reg_valid !== 1'b0) begin n_fail++; $display("FAIL reg_pulse_width: got %b want 0", reg_valid); end
    endtask

    task automatic test_pio();
        beat(32'h0000_205F, 1'b0);
        beat(32'h1111_1111, 1'b0);
        beat(32'h2222_2222, 1'b0);
        beat(32'hAB00_0000, 1'b0);
        beat(32'h0000_0200, 1'b1);
        n_tests++; if (pio_valid !== 1'b1 || pio_estatus !== 8'hAB || pio_xfer_cnt !== 16'h0200) begin n_fail++; $display("FAIL pio_capture: got %b/%h/%h want 1/ab/0200", pio_valid, pio_estatus, pio_xfer_cnt); end
        n_tests++; if (reg_valid !== 1'b0 || reg_status !== 8'h50 || reg_lba !== 48'h00789A123456) begin n_fail++; $display("FAIL pio_reg_hold: got %b/%h/%h", reg_valid, reg_status, reg_lba); end
        idle();
        n_tests++; if (pio_valid !== 1'b0) begin n_fail++; $display("FAIL pio_pulse_width: got %b want 0", pio_valid); end
    endtask

    task automatic test_data_128();
        int bad = 0;
        logic [31:0] exp;
        beat(32'h0000_0046, 1'b0);
        n_tests++; if (data_tvalid !== 1'b0) begin n_fail++; $display("FAIL data_hdr: data_tvalid %b want 0", data_tvalid); end
        for (int i = 1; i <= 128; i++) begin
            exp = 32'hA000_0000 + i;
            beat(exp, i == 128);
            n_tests++;
            if ({data_tvalid, data_tlast, data_tdata, fis_err, data_abort} !== {1'b1, i == 128, exp, 1'b0, 1'b0}) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL data_beat%0d: got v%b l%b d%h e%b a%b want v1 l%b d%h", i, data_tvalid, data_tlast, data_tdata, fis_err, data_abort, i == 128, exp);
            end
        end
        idle();
        n_tests++; if ({data_tvalid, data_tlast, fis_err, data_abort} !== 4'b0) begin n_fail++; $display("FAIL data_end: got %b want 0", {data_tvalid, data_tlast, fis_err, data_abort}); end
    endtask

    task automatic test_truncate();
        logic [31:0] exp;
        beat(32'h0000_0046, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            exp = 32'hC000_0000 + i;
            beat(exp, i == 6);
            if (i <= 4) begin
                n_tests++; if ({s_data_tvalid, s_data_tlast, s_data_tdata, s_data_abort, s_fis_err} !== {1'b1, i == 4, exp, 1'b0, 1'b0}) begin n_fail++; $display("FAIL trunc_beat%0d: got v%b l%b d%h a%b e%b want l%b d%h", i, s_data_tvalid, s_data_tlast, s_data_tdata, s_data_abort, s_fis_err, i == 4, exp); end
            end else begin
                n_tests++; if ({s_data_tvalid, s_data_abort, s_fis_err} !== {1'b0, i == 5, i == 5}) begin n_fail++; $display("FAIL trunc_after%0d: got v%b a%b e%b want v0 a%b e%b", i, s_data_tvalid, s_data_abort, s_fis_err, i == 5, i == 5); end
            end
        end
        idle();
        n_tests++; if ({s_data_tvalid, s_data_abort, s_fis_err} !== 3'b0) begin n_fail++; $display("FAIL trunc_skip_end: got %b want 0", {s_data_tvalid, s_data_abort, s_fis_err}); end
    endtask

    task automatic test_reg_short();
        beat(32'h1122_4434, 1'b0);
        beat(32'h33AA_BBCC, 1'b0);
        beat(32'h00DD_EEFF, 1'b0);
        beat(32'h0000_0077, 1'b1);
        n_tests++; if (fis_err !== 1'b1 || reg_valid !== 1'b0) begin n_fail++; $display("FAIL short_err: fis_err %b reg_valid %b want 1/0", fis_err, reg_valid); end
        n_tests++; if (reg_status !== 8'h50 || reg_device !== 8'hE0 || reg_lba !== 48'h00789A123456 || reg_count !== 16'h0010) begin n_fail++; $display("FAIL short_hold: got %h/%h/%h/%h", reg_status, reg_device, reg_lba, reg_count); end
        idle();
        n_tests++; if (fis_err !== 1'b0) begin n_fail++; $display("FAIL short_pulse_width: got %b want 0", fis_err); end
    endtask

    task automatic test_rfis_err();
        beat(32'h0000_0046, 1'b0);
        for (int i = 1; i <= 8; i++) beat(32'hD000_0000 + i, i == 8);
        idle();
        rfis_err = 1'b1;
        tick();
        rfis_err = 1'b0;
        n_tests++; if (fis_err !== 1'b1 || data_abort !== 1'b1) begin n_fail++; $display("FAIL err_pulse: fis_err %b data_abort %b want 1/1", fis_err, data_abort); end
        tick();
        n_tests++; if (fis_err !== 1'b0 || data_abort !== 1'b0) begin n_fail++; $display("FAIL err_width: fis_err %b data_abort %b want 0/0", fis_err, data_abort); end
        beat(32'h0000_0039, 1'b1);
        n_tests++; if (dma_act !== 1'b1 || fis_err !== 1'b0) begin n_fail++; $display("FAIL dma_act: got %b err %b want 1/0", dma_act, fis_err); end
        idle();
        n_tests++; if (dma_act !== 1'b0) begin n_fail++; $display("FAIL dma_width: got %b want 0", dma_act); end
    endtask

    task automatic test_back_to_back();
        beat(32'h0000_00A1, 1'b0);
        beat(32'h1234_5678, 1'b0);
        n_tests++; if (fis_err !== 1'b0) begin n_fail++; $display("FAIL skip_early: fis_err %b want 0", fis_err); end
        beat(32'h8765_4321, 1'b1);
        n_tests++; if (fis_err !== 1'b1) begin n_fail++; $display("FAIL skip_err: fis_err %b want 1", fis_err); end
        beat(32'h0000_0039, 1'b1);
        n_tests++; if (dma_act !== 1'b1 || fis_err !== 1'b0) begin n_fail++; $display("FAIL b2b_dma: got %b err %b want 1/0", dma_act, fis_err); end
        beat(32'h0000_0046, 1'b1);
        n_tests++; if (fis_err !== 1'b1 || dma_act !== 1'b0 || data_tvalid !== 1'b0) begin n_fail++; $display("FAIL empty_data: err %b dma %b v %b want 1/0/0", fis_err, dma_act, data_tvalid); end
        idle();
    endtask

    task automatic test_reset_mid();
        beat(32'h0000_0046, 1'b0);
        for (int i = 1; i <= 3; i++) beat(32'hE000_0000 + i, 1'b0);
        n_tests++; if (data_tvalid !== 1'b1 || data_tdata !== 32'hE000_0003) begin n_fail++; $display("FAIL mid_data: v %b d %h want 1/e0000003", data_tvalid, data_tdata); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({data_tvalid, data_tdata, reg_status, reg_lba, pio_xfer_cnt} !== '0) begin n_fail++; $display("FAIL async_reset: v %b d %h st %h lba %h", data_tvalid, data_tdata, reg_status, reg_lba); end
        rfis_tvalid = 1'b0; rfis_tlast = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        beat(32'h0151_0034, 1'b0);
        beat(32'hA000_0001, 1'b0);
        beat(32'h0000_0002, 1'b0);
        beat(32'h0000_0003, 1'b0);
        beat(32'h0000_0000, 1'b1);
        n_tests++; if (reg_valid !== 1'b1 || reg_status !== 8'h51 || reg_error !== 8'h01 || reg_irq !== 1'b0) begin n_fail++; $display("FAIL post_rst_status: got %b/%h/%h/%b want 1/51/01/0", reg_valid, reg_status, reg_error, reg_irq); end
        n_tests++; if (reg_lba !== 48'h000002000001 || reg_device !== 8'hA0 || reg_count !== 16'h0003) begin n_fail++; $display("FAIL post_rst_fields: got %h/%h/%h", reg_lba, reg_device, reg_count); end
        idle();
    endtask

    initial begin
        test_reset();
        test_reg_d2h();
        test_pio();
        test_data_128();
        test_truncate();
        test_reg_short();
        test_rfis_err();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
